// File: rtl/wb_timer.sv
// ---------------------------------------------------------------------------
// wb_timer : Wishbone slave 32-bit prescaled timer
//
// Sits on the MCU's 32-bit Wishbone bus behind the flash controller's master
// port. Provides a 32-bit count with a PW-bit prescaler, a compare/period
// register, auto-reload or one-shot operation, sticky W1C status flags and
// a registered level interrupt.
//
// Register map (adr_i[2:0]):
//   0 CTRL    [0] EN, [1] AUTO, [2] IE, [8+PW-1:8] PRESCALE
//   1 COUNT   current count, write loads it
//   2 PERIOD  compare value
//   3 STATUS  [0] MATCH, [1] OVF, [2] CAP (write-1-to-clear)
//   4 CAPTURE count latched on a cap_i rising edge (read-only)
//   5,6       read 0, writes ignored
//   7 ID      constant ID parameter
//
// Optional feature macro: WB_TIMER_CAPTURE_EN
//   defined   : cap_i rising edge latches COUNT into CAPTURE, sets STATUS.CAP
//   undefined : cap_i ignored, CAPTURE and STATUS[2] read 0
//
// Ports:
//   clk    system clock
//   arstn  asynchronous active-low reset
//   adr_i  Wishbone word address (15 bits)
//   dat_i  write data (32 bits)
//   dat_o  registered read data (32 bits)
//   we_i   write enable, qualified by stb_i
//   stb_i  strobe / cycle request
//   ack_o  one-cycle transfer acknowledge
//   cap_i  capture input, already synchronous to clk
//   irq    level interrupt, MATCH & IE, registered
// ---------------------------------------------------------------------------
module wb_timer #(
  parameter logic [14:0] BASE = 15'h0000,
  parameter logic [31:0] ID   = 32'h54494D31,
  parameter int          PW   = 8
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic [14:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  input  logic        cap_i,
  output logic        irq
);

  logic          en, auto_rl, ie;
  logic [PW-1:0] prescale;
  logic [PW-1:0] pc;
  logic [31:0]   count, period;
  logic          match, ovf;
  logic          cap_flag;
  logic [31:0]   capture;

  logic sel, acc, wr, rd;
  logic wr_ctrl, wr_count, wr_period, wr_status;
  logic tick, tick_eff, at_period, at_max;
  logic [31:0] ctrl_rd, rd_data;

  // An access happens only on the first selected cycle; the ack cycle itself
  // is ignored so a held strobe produces exactly one transfer.
  assign sel       = stb_i & (adr_i[14:3] == BASE[14:3]);
  assign acc       = sel & ~ack_o;
  assign wr        = acc & we_i;
  assign rd        = acc & ~we_i;
  assign wr_ctrl   = wr & (adr_i[2:0] == 3'd0);
  assign wr_count  = wr & (adr_i[2:0] == 3'd1);
  assign wr_period = wr & (adr_i[2:0] == 3'd2);
  assign wr_status = wr & (adr_i[2:0] == 3'd3);

  // A bus write to COUNT or CTRL takes priority and swallows a coincident tick.
  assign tick      = en & (pc == prescale);
  assign tick_eff  = tick & ~wr_ctrl & ~wr_count;
  assign at_period = (count == period);
  assign at_max    = &count;

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd[0]       = en;
    ctrl_rd[1]       = auto_rl;
    ctrl_rd[2]       = ie;
    ctrl_rd[8 +: PW] = prescale;
  end

  always_comb begin
    rd_data = '0;
    case (adr_i[2:0])
      3'd0:    rd_data = ctrl_rd;
      3'd1:    rd_data = count;
      3'd2:    rd_data = period;
      3'd3:    rd_data = {29'd0, cap_flag, ovf, match};
      3'd4:    rd_data = capture;
      3'd7:    rd_data = ID;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      irq      <= 1'b0;
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      pc       <= '0;
      count    <= '0;
      period   <= '0;
      match    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ack_o <= sel & ~ack_o;
      if (rd) dat_o <= rd_data;
      irq <= match & ie;

      // Prescaler restarts on any CTRL write so the first tick after enabling
      // comes a full PRESCALE+1 cycles later.
      if (wr_ctrl || !en || tick) pc <= '0;
      else                        pc <= pc + PW'(1);

      if (wr_ctrl) begin
        en       <= dat_i[0];
        auto_rl  <= dat_i[1];
        ie       <= dat_i[2];
        prescale <= dat_i[8 +: PW];
      end else if (tick_eff && at_period && !auto_rl) begin
        en <= 1'b0;
      end

      // On a one-shot match the count simply holds at PERIOD.
      if (wr_count) begin
        count <= dat_i;
      end else if (tick_eff) begin
        if (at_period) begin
          if (auto_rl) count <= '0;
        end else if (at_max) begin
          count <= '0;
        end else begin
          count <= count + 32'd1;
        end
      end

      if (wr_period) period <= dat_i;

      // Flag sets beat a same-cycle write-1-to-clear.
      if (tick_eff && at_period)               match <= 1'b1;
      else if (wr_status && dat_i[0])          match <= 1'b0;

      if (tick_eff && !at_period && at_max)    ovf <= 1'b1;
      else if (wr_status && dat_i[1])          ovf <= 1'b0;
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  logic cap_d;
  logic cap_edge;

  assign cap_edge = cap_i & ~cap_d;

  // CAPTURE takes COUNT as it stands before this edge's update; a read in
  // the same cycle still sees the previous CAPTURE value.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cap_d    <= 1'b0;
      capture  <= '0;
      cap_flag <= 1'b0;
    end else begin
      cap_d <= cap_i;
      if (cap_edge) capture <= count;
      if (cap_edge)                    cap_flag <= 1'b1;
      else if (wr_status && dat_i[2])  cap_flag <= 1'b0;
    end
  end
`else
  logic unused_cap;

  assign cap_flag   = 1'b0;
  assign capture    = '0;
  assign unused_cap = cap_i;
`endif

endmodule

// File: tb/tb_wb_timer.sv
// ---------------------------------------------------------------------------
// tb_wb_timer : self-checking bench for wb_timer
//
// A behavioural model of the timer (elapsed-cycle arithmetic for the
// prescaler, plain integer rules for count/flags) runs alongside the DUT and
// ack_o, irq and dat_o are compared with it every cycle. Directed sequences
// follow the timer's intended use, then randomized bus traffic follows.
// Honours WB_TIMER_CAPTURE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_wb_timer;

  localparam logic [14:0] BASE = 15'h0000;
  localparam logic [31:0] ID   = 32'h54494D31;
  localparam int          PW   = 8;

  logic        clk = 1'b0;
  logic        arstn;
  logic [14:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic        stb_i;
  logic        ack_o;
  logic        cap_i;
  logic        irq;

  int compared   = 0;
  int mismatched = 0;
  bit chk_on     = 1'b0;

  wb_timer #(.BASE(BASE), .ID(ID), .PW(PW)) dut (
    .clk   (clk),
    .arstn (arstn),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we_i),
    .stb_i (stb_i),
    .ack_o (ack_o),
    .cap_i (cap_i),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_en, m_auto, m_ie;
  logic [7:0]  m_ps;
  int          m_phase;
  logic [31:0] m_count, m_period, m_capture, m_dat;
  logic        m_match, m_ovf, m_capf, m_capprev, m_irq, m_ack;

  // Next-state values of the model
  logic        n_en, n_auto, n_ie;
  logic [7:0]  n_ps;
  int          n_phase;
  logic [31:0] n_count, n_period, n_capture, n_dat, rd_val;
  logic        n_match, n_ovf, n_capf, n_irq, n_ack;
  logic        t_sel, t_acc, t_wr, t_tick, t_mset, t_oset, t_cedge;
  logic [2:0]  t_a;

  always_comb begin
    t_sel   = stb_i && (adr_i[14:3] == BASE[14:3]);
    t_acc   = t_sel && !m_ack;
    t_wr    = t_acc && we_i;
    t_a     = adr_i[2:0];
    rd_val  = 32'd0;
    case (t_a)
      3'd0: rd_val = {16'd0, m_ps, 5'd0, m_ie, m_auto, m_en};
      3'd1: rd_val = m_count;
      3'd2: rd_val = m_period;
      3'd3: rd_val = {29'd0, m_capf, m_ovf, m_match};
      3'd4: rd_val = m_capture;
      3'd7: rd_val = ID;
      default: rd_val = 32'd0;
    endcase
    // A tick falls on every (PRESCALE+1)th enabled cycle since the last CTRL write.
    t_tick    = m_en && ((m_phase % (int'(m_ps) + 1)) == int'(m_ps));
    t_mset    = 1'b0;
    t_oset    = 1'b0;
    t_cedge   = 1'b0;
    n_en      = m_en;
    n_auto    = m_auto;
    n_ie      = m_ie;
    n_ps      = m_ps;
    n_count   = m_count;
    n_period  = m_period;
    n_capture = m_capture;
    n_capf    = m_capf;
    n_phase   = m_phase + 1;
    if (t_tick && !(t_wr && (t_a == 3'd0 || t_a == 3'd1))) begin
      if (m_count == m_period) begin
        t_mset = 1'b1;
        if (m_auto) n_count = 32'd0;
        else        n_en = 1'b0;
      end else if (m_count == 32'hFFFF_FFFF) begin
        n_count = 32'd0;
        t_oset  = 1'b1;
      end else begin
        n_count = m_count + 32'd1;
      end
    end
    if (t_wr && t_a == 3'd1) n_count = dat_i;
    if (t_wr && t_a == 3'd2) n_period = dat_i;
    if (t_wr && t_a == 3'd0) begin
      n_en    = dat_i[0];
      n_auto  = dat_i[1];
      n_ie    = dat_i[2];
      n_ps    = dat_i[15:8];
      n_phase = 0;
    end else if (!m_en) begin
      n_phase = 0;
    end
    n_match = t_mset || (m_match && !(t_wr && t_a == 3'd3 && dat_i[0]));
    n_ovf   = t_oset || (m_ovf && !(t_wr && t_a == 3'd3 && dat_i[1]));
`ifdef WB_TIMER_CAPTURE_EN
    t_cedge = cap_i && !m_capprev;
    if (t_cedge) n_capture = m_count;
    n_capf  = t_cedge || (m_capf && !(t_wr && t_a == 3'd3 && dat_i[2]));
`endif
    n_irq = m_match && m_ie;
    n_ack = t_sel && !m_ack;
    n_dat = (t_acc && !we_i) ? rd_val : m_dat;
  end

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_en <= 0; m_auto <= 0; m_ie <= 0; m_ps <= 0; m_phase <= 0;
      m_count <= 0; m_period <= 0; m_capture <= 0; m_dat <= 0;
      m_match <= 0; m_ovf <= 0; m_capf <= 0; m_capprev <= 0;
      m_irq <= 0; m_ack <= 0;
    end else begin
      m_en <= n_en; m_auto <= n_auto; m_ie <= n_ie; m_ps <= n_ps;
      m_phase <= n_phase; m_count <= n_count; m_period <= n_period;
      m_capture <= n_capture; m_dat <= n_dat; m_match <= n_match;
      m_ovf <= n_ovf; m_capf <= n_capf; m_capprev <= cap_i;
      m_irq <= n_irq; m_ack <= n_ack;
    end
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
      checkOutput("irq",   {31'd0, irq},   {31'd0, m_irq});
      checkOutput("dat_o", dat_o, m_dat);
    end
  end

  // One Wishbone transfer to a selected address, bounded wait for ack.
  task automatic applyStimulus(input logic we, input logic [2:0] a,
                               input logic [31:0] d, output logic [31:0] rdata);
    bit got;
    @(negedge clk);
    stb_i = 1'b1;
    we_i  = we;
    adr_i = {BASE[14:3], a};
    dat_i = d;
    got   = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ack_o) got = 1'b1;
    end
    rdata = dat_o;
    stb_i = 1'b0;
    we_i  = 1'b0;
    if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rdata;
  logic [31:0] rnd;
  logic [2:0]  ra;
  logic        rwe;

  initial begin
    arstn = 1'b1;
    stb_i = 1'b0;
    we_i  = 1'b0;
    adr_i = '0;
    dat_i = '0;
    cap_i = 1'b0;
    #2 arstn = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    arstn = 1'b1;

    // Reset arriving mid-transfer drops ack at once.
    @(negedge clk);
    stb_i = 1'b1;
    adr_i = {BASE[14:3], 3'd7};
    @(posedge clk);
    #2 arstn = 1'b0;
    #1 checkOutput("rst_ack", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    stb_i = 1'b0;
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    applyStimulus(1'b0, 3'd7, 32'd0, rdata);
    checkOutput("id", rdata, 32'h54494D31);

    // Auto-reload with PERIOD 3.
    applyStimulus(1'b1, 3'd2, 32'd3, rdata);
    applyStimulus(1'b1, 3'd0, 32'h0000_0003, rdata);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd1, 32'd0, rdata);
    applyStimulus(1'b0, 3'd3, 32'd0, rdata);
    checkOutput("auto_match", {31'd0, rdata[0]}, 32'd1);
    applyStimulus(1'b1, 3'd0, 32'd0, rdata);
    applyStimulus(1'b1, 3'd3, 32'd1, rdata);
    applyStimulus(1'b0, 3'd3, 32'd0, rdata);
    checkOutput("auto_w1c", rdata, 32'd0);

    // One-shot, prescale 4, interrupt enabled.
    applyStimulus(1'b1, 3'd1, 32'd0, rdata);
    applyStimulus(1'b1, 3'd2, 32'd2, rdata);
    applyStimulus(1'b1, 3'd0, 32'h0000_0405, rdata);
    repeat (25) @(negedge clk);
    applyStimulus(1'b0, 3'd1, 32'd0, rdata);
    checkOutput("oneshot_count", rdata, 32'd2);
    applyStimulus(1'b0, 3'd0, 32'd0, rdata);
    checkOutput("oneshot_ctrl", rdata, 32'h0000_0404);
    checkOutput("oneshot_irq", {31'd0, irq}, 32'd1);
    applyStimulus(1'b1, 3'd3, 32'd1, rdata);
    repeat (2) @(negedge clk);
    checkOutput("oneshot_irq_clr", {31'd0, irq}, 32'd0);

    // Wrap through all-ones, then one-shot match at 5.
    applyStimulus(1'b1, 3'd0, 32'd0, rdata);
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFE, rdata);
    applyStimulus(1'b1, 3'd2, 32'd5, rdata);
    applyStimulus(1'b1, 3'd0, 32'd1, rdata);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 3'd3, 32'd0, rdata);
    checkOutput("wrap_status", rdata & 32'd3, 32'd3);
    applyStimulus(1'b0, 3'd1, 32'd0, rdata);
    checkOutput("wrap_count", rdata, 32'd5);
    applyStimulus(1'b1, 3'd3, 32'd7, rdata);

    // COUNT write while ticking every cycle.
    applyStimulus(1'b1, 3'd2, 32'h0000_1000, rdata);
    applyStimulus(1'b1, 3'd0, 32'd1, rdata);
    applyStimulus(1'b1, 3'd1, 32'h0000_0200, rdata);
    applyStimulus(1'b0, 3'd1, 32'd0, rdata);
    checkOutput("count_collide", rdata, 32'h0000_0201);

    // W1C racing MATCH sets (period 1, auto, every cycle).
    applyStimulus(1'b1, 3'd0, 32'd0, rdata);
    applyStimulus(1'b1, 3'd1, 32'd0, rdata);
    applyStimulus(1'b1, 3'd2, 32'd1, rdata);
    applyStimulus(1'b1, 3'd0, 32'd3, rdata);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd3, 32'd1, rdata);
    applyStimulus(1'b1, 3'd0, 32'd0, rdata);
    applyStimulus(1'b1, 3'd3, 32'd7, rdata);

    // Foreign address: never acked, no state change.
    @(negedge clk);
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = {BASE[14:3] ^ 12'h001, 3'd1};
    dat_i = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    stb_i = 1'b0;
    we_i  = 1'b0;
    applyStimulus(1'b0, 3'd1, 32'd0, rdata);
    applyStimulus(1'b0, 3'd5, 32'd0, rdata);
    checkOutput("unmapped5", rdata, 32'd0);
    applyStimulus(1'b0, 3'd6, 32'd0, rdata);
    checkOutput("unmapped6", rdata, 32'd0);

    // Capture edge at COUNT 0x10.
    applyStimulus(1'b1, 3'd1, 32'h0000_0010, rdata);
    @(negedge clk);
    cap_i = 1'b1;
    repeat (2) @(negedge clk);
    cap_i = 1'b0;
    applyStimulus(1'b0, 3'd4, 32'd0, rdata);
`ifdef WB_TIMER_CAPTURE_EN
    checkOutput("capture", rdata, 32'h0000_0010);
`else
    checkOutput("capture", rdata, 32'd0);
`endif
    applyStimulus(1'b0, 3'd3, 32'd0, rdata);
`ifdef WB_TIMER_CAPTURE_EN
    checkOutput("cap_flag", {31'd0, rdata[2]}, 32'd1);
`else
    checkOutput("cap_flag", {31'd0, rdata[2]}, 32'd0);
`endif

    // Randomized traffic; the continuous model comparison does the checking.
    for (int i = 0; i < 400; i++) begin
      cap_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        stb_i = 1'b1;
        we_i  = 1'($urandom_range(0, 1));
        adr_i = {BASE[14:3] ^ 12'($urandom_range(1, 4095)), 3'($urandom_range(0, 7))};
        dat_i = $urandom;
        repeat (2) @(negedge clk);
        stb_i = 1'b0;
        we_i  = 1'b0;
      end else begin
        ra  = 3'($urandom_range(0, 7));
        rwe = 1'($urandom_range(0, 1));
        rnd = $urandom;
        case (ra)
          3'd0: rnd = rnd & 32'h0000_0307;
          3'd1: rnd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : 32'($urandom_range(0, 20));
          3'd2: rnd = 32'($urandom_range(0, 20));
          default: ;
        endcase
        applyStimulus(rwe, ra, rnd, rdata);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
